// File: rtl/snake_game_ctrl_if.sv
// Control/datapath bundle between the snake game sequencer and the board datapath.
// The master side is the sequencer; the slave side is the head/body/apple datapath.
interface snake_game_ctrl_if;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic       start;
  logic       pause;
  logic [6:0] headX;
  logic [6:0] headY;
  logic [6:0] appleX;
  logic [6:0] appleY;
  logic       body_at_probe;
  logic [6:0] probeX;
  logic [6:0] probeY;
  logic       dir_left;
  logic       dir_right;
  logic       dir_up;
  logic       dir_down;
  logic       step;
  logic       grow;
  logic       apple_req;
  logic       dead;
  logic [7:0] score;

  modport master (
    input  key_left, key_right, key_up, key_down, start, pause,
    input  headX, headY, appleX, appleY, body_at_probe,
    output probeX, probeY, dir_left, dir_right, dir_up, dir_down,
    output step, grow, apple_req, dead, score
  );

  modport slave (
    output key_left, key_right, key_up, key_down, start, pause,
    output headX, headY, appleX, appleY, body_at_probe,
    input  probeX, probeY, dir_left, dir_right, dir_up, dir_down,
    input  step, grow, apple_req, dead, score
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: key filtering, move pacing, collision pre-check through
// the body probe, step/grow/apple_req strobes, IDLE->RUN->DEAD lifecycle and score.
module snake_game_ctrl #(
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int TICK_CYCLES = 5000000
) (
  input logic              clk,
  input logic              reset,
  snake_game_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TICK_CYCLES + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  // Opposite directions are bitwise complements in this encoding.
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_CHECK = 2'b10,
    S_DEAD  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             pending_q, pending_d;
  dir_t             committed_q, committed_d;
  logic [7:0]       score_q, score_d;
  logic             apple_req_p1;

  logic       step_c;
  logic       grow_c;
  logic [3:0] keys;
  logic       key_valid;
  dir_t       key_dir;
  logic [6:0] probe_x;
  logic [6:0] probe_y;
  logic       hit_apple;
  logic       dir_active;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? 8'hFF : s + 8'd1;
  endfunction

  function automatic logic [6:0] wrap_inc(input logic [6:0] c, input logic [6:0] last);
    return (c == last) ? 7'd0 : c + 7'd1;
  endfunction

  function automatic logic [6:0] wrap_dec(input logic [6:0] c, input logic [6:0] last);
    return (c == 7'd0) ? last : c - 7'd1;
  endfunction

  // Key decode: only a single pressed key names a direction.
  always_comb begin
    keys      = {bus.key_left, bus.key_right, bus.key_up, bus.key_down};
    key_valid = $onehot(keys);
    key_dir   = DIR_UP;
    case (keys)
      4'b1000: key_dir = DIR_LEFT;
      4'b0100: key_dir = DIR_RIGHT;
      4'b0010: key_dir = DIR_UP;
      4'b0001: key_dir = DIR_DOWN;
      default: key_dir = DIR_UP;
    endcase
  end

  // Next head position in the pending direction, wrapping at the board edges.
  always_comb begin
    probe_x = bus.headX;
    probe_y = bus.headY;
    case (pending_q)
      DIR_LEFT:  probe_x = wrap_dec(bus.headX, X_LAST);
      DIR_RIGHT: probe_x = wrap_inc(bus.headX, X_LAST);
      DIR_UP:    probe_y = wrap_dec(bus.headY, Y_LAST);
      DIR_DOWN:  probe_y = wrap_inc(bus.headY, Y_LAST);
      default:   probe_x = bus.headX;
    endcase
    hit_apple = (probe_x == bus.appleX) && (probe_y == bus.appleY);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    committed_d = committed_q;
    score_d     = score_q;
    step_c      = 1'b0;
    grow_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          pending_d   = key_dir;
          committed_d = key_dir;
          cnt_d       = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (key_valid && (key_dir != opposite(committed_q))) begin
          pending_d = key_dir;
        end
        if (!bus.pause) begin
          if (cnt_q == TICK_LAST) begin
            cnt_d   = '0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (bus.body_at_probe) begin
          state_d = S_DEAD;
        end else begin
          step_c      = 1'b1;
          grow_c      = hit_apple;
          committed_d = pending_q;
          if (hit_apple) begin
            score_d = sat_inc(score_q);
          end
          // pending_q becomes the committed direction at this edge
          if (key_valid && (key_dir != opposite(pending_q))) begin
            pending_d = key_dir;
          end
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_DEAD: begin
        if (bus.start) begin
          score_d = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      pending_q    <= DIR_UP;
      committed_q  <= DIR_UP;
      score_q      <= 8'd0;
      apple_req_p1 <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      committed_q  <= committed_d;
      score_q      <= score_d;
      apple_req_p1 <= grow_c;
    end
  end

  assign dir_active    = (state_q == S_RUN) || (state_q == S_CHECK);
  assign bus.probeX    = probe_x;
  assign bus.probeY    = probe_y;
  assign bus.dir_left  = dir_active && (committed_q == DIR_LEFT);
  assign bus.dir_right = dir_active && (committed_q == DIR_RIGHT);
  assign bus.dir_up    = dir_active && (committed_q == DIR_UP);
  assign bus.dir_down  = dir_active && (committed_q == DIR_DOWN);
  assign bus.step      = step_c;
  assign bus.grow      = grow_c;
  assign bus.apple_req = apple_req_p1;
  assign bus.dead      = (state_q == S_DEAD);
  assign bus.score     = score_q;

endmodule
